// File: rtl/cpm_miso_arbiter.sv
// Round-robin arbiter feeding one multi-input burst FIFO from NUM_REQ CPM requesters.
// Optional macro CPM_ARB_STAT_EN adds a saturating WAIT-cycle counter output stall_cnt.
module cpm_miso_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_NUMAW = 3
) (
    input  logic                                          clk,
    input  logic                                          Reset,
    input  logic [NUM_REQ-1:0]                            req,
    input  logic [NUM_REQ*DATA_NUMAW-1:0]                 req_num,
    input  logic [NUM_REQ*(1<<DATA_NUMAW)*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]                            req_ack,
    input  logic [ADDR_WIDTH:0]                           fifo_count_empty,
    input  logic                                          fifo_empty,
    output logic                                          fifo_push,
    output logic [(1<<DATA_NUMAW)*DATA_WIDTH-1:0]         fifo_data_in,
    output logic [DATA_NUMAW-1:0]                         fifo_data_num,
    input  logic                                          flush,
    output logic                                          flush_done,
    output logic                                          busy,
    output logic [1:0]                                    dbg_state_o
`ifdef CPM_ARB_STAT_EN
    ,
    output logic [15:0]                                   stall_cnt
`endif
);
    localparam int MAXN = 1 << DATA_NUMAW;
    localparam int BW   = MAXN * DATA_WIDTH;
    localparam int IDW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW   = (DATA_NUMAW > ADDR_WIDTH) ? DATA_NUMAW + 1 : ADDR_WIDTH + 1;

    // Valid/ready: req[i] with req_num/req_data held stable is "valid"; req_ack[i] is a
    // one-cycle accept pulse in the same cycle the burst appears on the FIFO push port.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  state_q;
    logic [IDW-1:0]          rr_ptr_q;
    logic [IDW-1:0]          lock_id_q;
    logic                    push_q;
    logic [NUM_REQ-1:0]      ack_q;
    logic [BW-1:0]           data_q;
    logic [DATA_NUMAW-1:0]   num_q;
    logic                    done_q;
    logic                    busy_q;

    logic [NUM_REQ-1:0]      elig;
    logic                    found;
    logic [IDW-1:0]          cand;
    logic [CW-1:0]           cnt_ext;
    logic [CW-1:0]           inflight;
    logic [CW-1:0]           space_eff;
    logic [IDW-1:0]          gnt_id;
    logic [CW-1:0]           gnt_need;
    logic                    gnt_go;
    logic [IDW-1:0]          gnt_next_ptr;

    always_comb begin
        elig  = req & ~ack_q;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!found && elig[idx]) begin
                found = 1'b1;
                cand  = IDW'(idx);
            end
        end

        // Space already promised to last cycle's push is not yet visible in the count.
        cnt_ext   = CW'(fifo_count_empty);
        inflight  = push_q ? (CW'(num_q) + CW'(1)) : '0;
        space_eff = (cnt_ext >= inflight) ? (cnt_ext - inflight) : '0;

        gnt_id       = (state_q == S_WAIT) ? lock_id_q : cand;
        gnt_need     = CW'(req_num[gnt_id*DATA_NUMAW +: DATA_NUMAW]) + CW'(1);
        gnt_next_ptr = IDW'((int'(gnt_id) + 1) % NUM_REQ);
        gnt_go       = 1'b0;
        if (!flush) begin
            if (state_q == S_IDLE)
                gnt_go = found && (gnt_need <= space_eff);
            else if (state_q == S_WAIT)
                gnt_go = req[lock_id_q] && (gnt_need <= space_eff);
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            lock_id_q <= '0;
            push_q    <= 1'b0;
            ack_q     <= '0;
            data_q    <= '0;
            num_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            push_q <= 1'b0;
            ack_q  <= '0;
            done_q <= 1'b0;
            if (gnt_go) begin
                push_q   <= 1'b1;
                ack_q    <= NUM_REQ'(1) << gnt_id;
                data_q   <= req_data[gnt_id*BW +: BW];
                num_q    <= req_num[gnt_id*DATA_NUMAW +: DATA_NUMAW];
                rr_ptr_q <= gnt_next_ptr;
            end
            case (state_q)
                S_IDLE: begin
                    if (flush) begin
                        state_q <= S_DRAIN;
                        busy_q  <= 1'b1;
                    end else if (found && !gnt_go) begin
                        lock_id_q <= cand;
                        state_q   <= S_WAIT;
                        busy_q    <= 1'b1;
                    end
                end
                S_WAIT: begin
                    // Only the locked requester may proceed, so large bursts cannot starve.
                    if (flush) begin
                        state_q <= S_DRAIN;
                    end else if (gnt_go || !req[lock_id_q]) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (fifo_empty && !push_q) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CPM_ARB_STAT_EN
    logic [15:0] stall_q;
    always_ff @(posedge clk) begin
        if (Reset || done_q)
            stall_q <= '0;
        else if (state_q == S_WAIT && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
    end
    assign stall_cnt = stall_q;
`endif

    assign req_ack       = ack_q;
    assign fifo_push     = push_q;
    assign fifo_data_in  = data_q;
    assign fifo_data_num = num_q;
    assign flush_done    = done_q;
    assign busy          = busy_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_cpm_miso_arbiter.sv
// Directed self-checking bench for cpm_miso_arbiter (default build, 8-bit words).
module tb_cpm_miso_arbiter;
    localparam int NR   = 4;
    localparam int DW   = 8;
    localparam int AW   = 4;
    localparam int NAW  = 3;
    localparam int MAXN = 8;
    localparam int BW   = MAXN * DW;
    localparam logic [1:0] ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_DRAIN = 2'd2;

    logic              clk = 1'b0;
    logic              Reset;
    logic [NR-1:0]     req;
    logic [NR*NAW-1:0] req_num;
    logic [NR*BW-1:0]  req_data;
    logic [NR-1:0]     req_ack;
    logic [AW:0]       fifo_count_empty;
    logic              fifo_empty;
    logic              fifo_push;
    logic [BW-1:0]     fifo_data_in;
    logic [NAW-1:0]    fifo_data_num;
    logic              flush;
    logic              flush_done;
    logic              busy;
    logic [1:0]        dbg_state_o;

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] exp_q[$];

    cpm_miso_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DATA_NUMAW(NAW)) dut (
        .clk(clk), .Reset(Reset), .req(req), .req_num(req_num), .req_data(req_data),
        .req_ack(req_ack), .fifo_count_empty(fifo_count_empty), .fifo_empty(fifo_empty),
        .fifo_push(fifo_push), .fifo_data_in(fifo_data_in), .fifo_data_num(fifo_data_num),
        .flush(flush), .flush_done(flush_done), .busy(busy), .dbg_state_o(dbg_state_o)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        req = '0;
        flush = 1'b0;
        fifo_empty = 1'b1;
        fifo_count_empty = 5'd16;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    // Driver tasks
    function automatic logic [BW-1:0] pat(int i);
        logic [BW-1:0] p;
        for (int w = 0; w < MAXN; w++) p[w*DW +: DW] = 8'((i << 4) + w + 1);
        return p;
    endfunction

    task automatic set_num(int i, int n);
        req_num[i*NAW +: NAW] = 3'(n);
    endtask

    // Scoreboard check
    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_idle_outs(string tag);
        check({tag, "_push"}, 64'(fifo_push), 64'd0);
        check({tag, "_ack"}, 64'(req_ack), 64'd0);
    endtask

    initial begin
        req_num = '0;
        for (int i = 0; i < NR; i++) req_data[i*BW +: BW] = pat(i);
        do_reset();
        check("rst_state", 64'(dbg_state_o), 64'(ST_IDLE));
        check("rst_outs", {fifo_push, req_ack, flush_done, busy, fifo_data_num}, 64'd0);
        check("rst_data", fifo_data_in, 64'd0);

        // 1: single grant, one-cycle latency
        req = 4'b0001; set_num(0, 2);
        tick();
        check("t1_push", 64'(fifo_push), 64'd1);
        check("t1_num", 64'(fifo_data_num), 64'd2);
        check("t1_ack", 64'(req_ack), 64'b0001);
        check("t1_data", fifo_data_in, pat(0));
        req = '0;
        tick();
        check_idle_outs("t1_after");
        check("t1_hold", 64'(fifo_data_num), 64'd2);

        // 2: all four requesting, round-robin 0,1,2,3,0
        do_reset();
        req_num = '0;
        req = 4'b1111;
        exp_q = {64'b0001, 64'b0010, 64'b0100, 64'b1000, 64'b0001};
        for (int k = 0; k < 5; k++) begin
            logic [63:0] e;
            tick();
            e = exp_q.pop_front();
            check($sformatf("t2_ack%0d", k), 64'(req_ack), e);
            check($sformatf("t2_push%0d", k), 64'(fifo_push), 64'd1);
            check($sformatf("t2_data%0d", k), fifo_data_in, pat($clog2(int'(e))));
        end
        req = '0;
        tick();
        check_idle_outs("t2_end");

        // 3: in-flight accounting with a stale free count
        do_reset();
        fifo_count_empty = 5'd9;
        req = 4'b0010; set_num(1, 7);
        tick();
        check("t3_ack1", 64'(req_ack), 64'b0010);
        check("t3_num1", 64'(fifo_data_num), 64'd7);
        req = 4'b0100; set_num(2, 3);
        tick();
        check_idle_outs("t3_wait");
        check("t3_state", 64'(dbg_state_o), 64'(ST_WAIT));
        check("t3_busy", 64'(busy), 64'd1);
        check("t3_hold", fifo_data_in, pat(1));
        fifo_count_empty = 5'd1;
        tick();
        check_idle_outs("t3_wait2");
        fifo_count_empty = 5'd4;
        tick();
        check("t3_ack2", 64'(req_ack), 64'b0100);
        check("t3_num2", 64'(fifo_data_num), 64'd3);
        check("t3_data2", fifo_data_in, pat(2));
        check("t3_idle", 64'(dbg_state_o), 64'(ST_IDLE));
        check("t3_busy0", 64'(busy), 64'd0);
        req = '0;

        // 4: locked large burst is not bypassed by a small one
        do_reset();
        fifo_count_empty = 5'd3;
        req = 4'b0011; set_num(0, 5); set_num(1, 0);
        tick();
        check("t4_state", 64'(dbg_state_o), 64'(ST_WAIT));
        tick();
        check_idle_outs("t4_nobypass");
        fifo_count_empty = 5'd7;
        tick();
        check("t4_ack0", 64'(req_ack), 64'b0001);
        check("t4_num0", 64'(fifo_data_num), 64'd5);
        req = 4'b0010;
        tick();
        check("t4_ack1", 64'(req_ack), 64'b0010);
        check("t4_push1", 64'(fifo_push), 64'd1);
        req = '0;

        // 5: flush in WAIT abandons the locked request
        do_reset();
        fifo_count_empty = 5'd3; fifo_empty = 1'b0;
        req = 4'b0001; set_num(0, 5);
        tick();
        check("t5_wait", 64'(dbg_state_o), 64'(ST_WAIT));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t5_drain", 64'(dbg_state_o), 64'(ST_DRAIN));
        check("t5_busy", 64'(busy), 64'd1);
        check_idle_outs("t5_noack");
        fifo_count_empty = 5'd16;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_idle_outs("t5_nogrant");
        check("t5_nodone", 64'(flush_done), 64'd0);
        req = '0; fifo_empty = 1'b1;
        tick();
        check("t5_done", 64'(flush_done), 64'd1);
        check("t5_idle", 64'(dbg_state_o), 64'(ST_IDLE));
        check("t5_busy0", 64'(busy), 64'd0);
        tick();
        check("t5_done_pulse", 64'(flush_done), 64'd0);

        // 5b: flush beats a grant in IDLE
        req = 4'b0001; set_num(0, 0); flush = 1'b1;
        tick();
        flush = 1'b0; req = '0;
        check("t5b_push", 64'(fifo_push), 64'd0);
        check("t5b_state", 64'(dbg_state_o), 64'(ST_DRAIN));
        tick();
        check("t5b_done", 64'(flush_done), 64'd1);

        // 6: reset mid-WAIT restarts the scan at requester 0
        do_reset();
        req = 4'b0010; set_num(1, 0);
        tick();
        check("t6_ack1", 64'(req_ack), 64'b0010);
        fifo_count_empty = 5'd3;
        req = 4'b1000; set_num(3, 5);
        tick();
        check("t6_wait", 64'(dbg_state_o), 64'(ST_WAIT));
        req = 4'b1001; set_num(0, 0);
        Reset = 1'b1;
        tick();
        check("t6_rst_state", 64'(dbg_state_o), 64'(ST_IDLE));
        check("t6_rst_outs", {fifo_push, req_ack, flush_done, busy, fifo_data_num}, 64'd0);
        Reset = 1'b0; set_num(3, 0); fifo_count_empty = 5'd16;
        tick();
        check("t6_first", 64'(req_ack), 64'b0001);
        req = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
